// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble: converts BIN_W-bit unsigned binary to DIGITS packed BCD digits in BIN_W+1 cycles.
// start is accepted only while busy=0; outputs are registered and change only on the done pulse or reset.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      bin,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [DIGITS-1:0]   BLANK_RST = ~DIGITS'(1);
    localparam logic [4*DIGITS-1:0] BCD_SAT   = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              state;
    logic [BIN_W-1:0]    shreg;
    logic [4*DIGITS-1:0] scratch;
    logic                carry;
    logic [CNT_W-1:0]    cnt;

    logic [4*DIGITS-1:0] adj;
    logic [DIGITS-1:0]   blank_next;
    logic                zero_run;

    always_comb begin
        adj        = '0;
        blank_next = '0;
        zero_run   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = (scratch[4*i +: 4] >= 4'd5) ? scratch[4*i +: 4] + 4'd3
                                                        : scratch[4*i +: 4];
        end
        // A digit is blank only if it and every digit above it are zero; the ones digit always shows.
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run      = zero_run & (scratch[4*i +: 4] == 4'd0);
            blank_next[i] = zero_run;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            shreg    <= '0;
            scratch  <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            blank    <= BLANK_RST;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shreg   <= bin;
                        scratch <= '0;
                        carry   <= 1'b0;
                        cnt     <= CNT_W'(BIN_W);
                        busy    <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Any bit leaving the top digit means the value no longer fits in DIGITS digits.
                    scratch <= {adj[4*DIGITS-2:0], shreg[BIN_W-1]};
                    shreg   <= {shreg[BIN_W-2:0], 1'b0};
                    carry   <= carry | adj[4*DIGITS-1];
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    bcd      <= carry ? BCD_SAT : scratch;
                    blank    <= carry ? '0 : blank_next;
                    overflow <= carry;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: scoreboard-checked conversions on a 4-digit instance plus a 3-digit overflow instance.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  bin = '0;
    logic        start = 1'b0;
    logic        busy, done, overflow;
    logic [15:0] bcd;
    logic [3:0]  blank;

    logic [9:0]  bin3 = '0;
    logic        start3 = 1'b0;
    logic        busy3, done3, overflow3;
    logic [11:0] bcd3;
    logic [2:0]  blank3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic rst_q = 1'b0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(10), .DIGITS(4)) dut (
        .clk(clk), .rst(rst), .bin(bin), .start(start), .busy(busy), .done(done),
        .bcd(bcd), .blank(blank), .overflow(overflow)
    );

    bin_to_bcd_seq #(.BIN_W(10), .DIGITS(3)) dut3 (
        .clk(clk), .rst(rst), .bin(bin3), .start(start3), .busy(busy3), .done(done3),
        .bcd(bcd3), .blank(blank3), .overflow(overflow3)
    );

    typedef struct {
        logic [9:0]  bin;
        logic [15:0] bcd;
        logic [3:0]  blank;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  blank;
        logic        ovf;
        int          start_cyc;
    } exp_t;

    typedef struct {
        logic [9:0]  bin;
        logic [11:0] bcd;
        logic [2:0]  blank;
        logic        ovf;
    } vec3_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Output shadow: reset values after reset, scoreboard values after each done, held otherwise.
    logic        armed = 1'b0;
    logic        prev_done = 1'b0;
    logic [15:0] sh_bcd = '0;
    logic [3:0]  sh_blank = 4'b1110;
    logic        sh_ovf = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_q) armed = 1'b1;
        if (armed) begin
            if (rst_q) begin
                sh_bcd = '0; sh_blank = 4'b1110; sh_ovf = 1'b0;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
            end else if (done) begin
                chk("done_width", 32'(prev_done), 32'd0);
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done=1 bcd=%0h, required no pulse (cycle %0d)", bcd, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("latency", 32'(cyc - e.start_cyc), 32'd11);
                    sh_bcd = e.bcd; sh_blank = e.blank; sh_ovf = e.ovf;
                end
            end
            chk("bcd", 32'(bcd), 32'(sh_bcd));
            chk("blank", 32'(blank), 32'(sh_blank));
            chk("overflow", 32'(overflow), 32'(sh_ovf));
            prev_done = done;
        end
    end

    task automatic conv(input logic [9:0] b, input logic [15:0] eb, input logic [3:0] ebl);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL conv_wait: busy=%0b, required 0 within 100 cycles", busy);
        end
        bin = b;
        start = 1'b1;
        e.bcd = eb; e.blank = ebl; e.ovf = 1'b0; e.start_cyc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d results pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic conv3(input vec3_t v);
        int n = 0;
        @(negedge clk);
        while (busy3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        bin3 = v.bin;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        n = 0;
        while (!done3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done3) begin
            checks++; errors++;
            $display("FAIL d3_timeout: done3=0, required pulse for bin=%0d", v.bin);
        end else begin
            chk("d3_bcd", 32'(bcd3), 32'(v.bcd));
            chk("d3_blank", 32'(blank3), 32'(v.blank));
            chk("d3_overflow", 32'(overflow3), 32'(v.ovf));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl[10];
        vec3_t tbl3[6];
        int    n;

        tbl[0] = '{10'd1023, 16'h1023, 4'b0000, 1'b0};
        tbl[1] = '{10'd7,    16'h0007, 4'b1110, 1'b0};
        tbl[2] = '{10'd0,    16'h0000, 4'b1110, 1'b0};
        tbl[3] = '{10'd999,  16'h0999, 4'b1000, 1'b0};
        tbl[4] = '{10'd512,  16'h0512, 4'b1000, 1'b0};
        tbl[5] = '{10'd10,   16'h0010, 4'b1100, 1'b0};
        tbl[6] = '{10'd100,  16'h0100, 4'b1000, 1'b0};
        tbl[7] = '{10'd1000, 16'h1000, 4'b0000, 1'b0};
        tbl[8] = '{10'd5,    16'h0005, 4'b1110, 1'b0};
        tbl[9] = '{10'd99,   16'h0099, 4'b1100, 1'b0};

        tbl3[0] = '{10'd1000, 12'h999, 3'b000, 1'b1};
        tbl3[1] = '{10'd42,   12'h042, 3'b100, 1'b0};
        tbl3[2] = '{10'd1023, 12'h999, 3'b000, 1'b1};
        tbl3[3] = '{10'd999,  12'h999, 3'b000, 1'b0};
        tbl3[4] = '{10'd0,    12'h000, 3'b110, 1'b0};
        tbl3[5] = '{10'd7,    12'h007, 3'b110, 1'b0};

        // Reset, then idle for 20 cycles with outputs held at reset values.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Full-scale conversion: busy must stay high for exactly 11 cycles.
        conv(10'd1023, 16'h1023, 4'b0000);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", 32'(n), 32'd11);
        drain();

        for (int i = 0; i < 10; i++) begin
            conv(tbl[i].bin, tbl[i].bcd, tbl[i].blank);
        end
        drain();

        // Starts while busy (mid-shift and in the DONE state) are ignored.
        conv(10'd250, 16'h0250, 4'b1000);
        for (int j = 2; j <= 12; j++) begin
            @(negedge clk);
            start = (j == 4 || j == 11);
            bin = (j == 4 || j == 11) ? 10'd999 : 10'd0;
        end
        start = 1'b0;
        conv(10'd999, 16'h0999, 4'b1000);
        drain();

        for (int i = 0; i < 6; i++) begin
            conv3(tbl3[i]);
        end

        // Reset mid-conversion aborts without a done pulse; start alongside reset is dropped.
        conv(10'd123, 16'h0123, 4'b1000);
        drain();
        conv(10'd512, 16'h0512, 4'b1000);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        bin = 10'd77;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        repeat (15) @(negedge clk);
        conv(10'd512, 16'h0512, 4'b1000);
        drain();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
